// File: rtl/ysyx_24080006_axi_arb.sv
// Read/write arbiter: IFU and LSU masters share one downstream AXI-style port.
// One transaction is outstanding at a time, and one IDLE arbitration cycle separates transactions.
package ysyx_24080006_axi_pkg;
  typedef struct packed {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi_r_s2m_t;

  typedef struct packed {
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic       bvalid;
    logic [1:0] bresp;
  } axi_w_s2m_t;
endpackage

module ysyx_24080006_axi_arb
  import ysyx_24080006_axi_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  input  axi_w_m2s_t lsu_w_m2s,
  output axi_w_s2m_t lsu_w_s2m,
  output axi_r_m2s_t mem_r_m2s,
  input  axi_r_s2m_t mem_r_s2m,
  output axi_w_m2s_t mem_w_m2s,
  input  axi_w_s2m_t mem_w_s2m
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR     = 2'd3
  } state_t;

  localparam logic LAST_IFU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

  state_t state_reg, state_next;
  logic   aw_done_reg, aw_done_next;
  logic   w_done_reg, w_done_next;
  logic   last_rd_reg, last_rd_next;

  logic aw_hs, w_last_hs, b_hs;
  logic ifu_rd_end, lsu_rd_end, lsu_rd_wins;

  // Once an address or the final data beat has been accepted, it is masked so it cannot be issued twice.
  assign aw_hs      = (state_reg == WR) && lsu_w_m2s.awvalid && !aw_done_reg && mem_w_s2m.awready;
  assign w_last_hs  = (state_reg == WR) && lsu_w_m2s.wvalid && !w_done_reg && mem_w_s2m.wready
                      && lsu_w_m2s.wlast;
  assign b_hs       = (state_reg == WR) && mem_w_s2m.bvalid && lsu_w_m2s.bready;
  assign ifu_rd_end = mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast;
  assign lsu_rd_end = mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast;
  assign lsu_rd_wins = RR_EN ? (last_rd_reg == LAST_IFU) : 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      last_rd_reg <= LAST_IFU;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      last_rd_reg <= last_rd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    last_rd_next = last_rd_reg;
    case (state_reg)
      IDLE: begin
        if (lsu_w_m2s.awvalid) begin
          state_next = WR;
        end else if (lsu_r_m2s.arvalid && (!ifu_r_m2s.arvalid || lsu_rd_wins)) begin
          state_next   = RD_LSU;
          last_rd_next = LAST_LSU;
        end else if (ifu_r_m2s.arvalid) begin
          state_next   = RD_IFU;
          last_rd_next = LAST_IFU;
        end
      end
      RD_IFU: if (ifu_rd_end) state_next = IDLE;
      RD_LSU: if (lsu_rd_end) state_next = IDLE;
      WR: begin
        // A write response ends the transaction even if AW/W completion was never observed.
        if (b_hs) begin
          state_next   = IDLE;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          if (aw_hs)     aw_done_next = 1'b1;
          if (w_last_hs) w_done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_r_m2s = '0;
    mem_w_m2s = '0;
    ifu_r_s2m = '0;
    lsu_r_s2m = '0;
    lsu_w_s2m = '0;
    case (state_reg)
      RD_IFU: begin
        mem_r_m2s = ifu_r_m2s;
        ifu_r_s2m = mem_r_s2m;
      end
      RD_LSU: begin
        mem_r_m2s = lsu_r_m2s;
        lsu_r_s2m = mem_r_s2m;
      end
      WR: begin
        mem_w_m2s         = lsu_w_m2s;
        mem_w_m2s.awvalid = lsu_w_m2s.awvalid & ~aw_done_reg;
        mem_w_m2s.wvalid  = lsu_w_m2s.wvalid & ~w_done_reg;
        lsu_w_s2m         = mem_w_s2m;
        lsu_w_s2m.awready = mem_w_s2m.awready & ~aw_done_reg;
        lsu_w_s2m.wready  = mem_w_s2m.wready & ~w_done_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_arb.sv
// Bench for the IFU/LSU arbiter: requester tasks push expected beats and write responses,
// and a negedge monitor pops and compares them when the DUT delivers them.
module tb_ysyx_24080006_axi_arb;
  import ysyx_24080006_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_r_m2s_t ifu_r_m2s, lsu_r_m2s, mem_r_m2s;
  axi_r_s2m_t ifu_r_s2m, lsu_r_s2m, mem_r_s2m;
  axi_w_m2s_t lsu_w_m2s, mem_w_m2s;
  axi_w_s2m_t lsu_w_s2m, mem_w_s2m;

  axi_r_m2s_t fp_ifu_r_m2s, fp_lsu_r_m2s, fp_mem_r_m2s;
  axi_r_s2m_t fp_ifu_r_s2m, fp_lsu_r_s2m, fp_mem_r_s2m;
  axi_w_m2s_t fp_lsu_w_m2s, fp_mem_w_m2s;
  axi_w_s2m_t fp_lsu_w_s2m, fp_mem_w_s2m;

  ysyx_24080006_axi_arb #(.RR_EN(1'b1)) dut (
    .clock(clk), .reset(rst),
    .ifu_r_m2s(ifu_r_m2s), .ifu_r_s2m(ifu_r_s2m),
    .lsu_r_m2s(lsu_r_m2s), .lsu_r_s2m(lsu_r_s2m),
    .lsu_w_m2s(lsu_w_m2s), .lsu_w_s2m(lsu_w_s2m),
    .mem_r_m2s(mem_r_m2s), .mem_r_s2m(mem_r_s2m),
    .mem_w_m2s(mem_w_m2s), .mem_w_s2m(mem_w_s2m)
  );

  // Fixed-priority variant, kept permanently in a read tie.
  ysyx_24080006_axi_arb #(.RR_EN(1'b0)) dut_fp (
    .clock(clk), .reset(rst),
    .ifu_r_m2s(fp_ifu_r_m2s), .ifu_r_s2m(fp_ifu_r_s2m),
    .lsu_r_m2s(fp_lsu_r_m2s), .lsu_r_s2m(fp_lsu_r_s2m),
    .lsu_w_m2s(fp_lsu_w_m2s), .lsu_w_s2m(fp_lsu_w_s2m),
    .mem_r_m2s(fp_mem_r_m2s), .mem_r_s2m(fp_mem_r_s2m),
    .mem_w_m2s(fp_mem_w_m2s), .mem_w_s2m(fp_mem_w_s2m)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      ifu_q[$];
  beat_t      lsu_q[$];
  logic [1:0] b_q[$];
  beat_t      mon_ifu_b, mon_lsu_b;
  logic [1:0] mon_bresp;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int b);
    return (a + 32'(b) * 32'd4) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] resp);
    for (int b = 0; b <= int'(len); b++) ifu_q.push_back('{mem_word(a, b), resp, b == int'(len)});
    ifu_r_m2s.araddr  = a;
    ifu_r_m2s.arlen   = len;
    ifu_r_m2s.arvalid = 1'b1;
  endtask

  task automatic lsu_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] resp);
    for (int b = 0; b <= int'(len); b++) lsu_q.push_back('{mem_word(a, b), resp, b == int'(len)});
    lsu_r_m2s.araddr  = a;
    lsu_r_m2s.arlen   = len;
    lsu_r_m2s.arvalid = 1'b1;
  endtask

  task automatic lsu_wr_start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    b_q.push_back(resp);
    lsu_w_m2s.awaddr  = a;
    lsu_w_m2s.awlen   = 8'd0;
    lsu_w_m2s.awvalid = 1'b1;
    lsu_w_m2s.wdata   = d;
    lsu_w_m2s.wstrb   = 4'hF;
    lsu_w_m2s.wlast   = 1'b1;
    lsu_w_m2s.wvalid  = 1'b1;
    lsu_w_m2s.bready  = 1'b1;
  endtask

  // Downstream memory: waits for an AR, accepts it, then returns up to max_beats beats.
  task automatic serve_read(input string tag, input logic [31:0] exp_addr, input int exp_wait,
                            input logic [1:0] resp, input int max_beats);
    int n = 0;
    logic [31:0] a;
    logic [7:0]  len;
    logic took_ifu, took_lsu;
    @(negedge clk);
    while (!mem_r_m2s.arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ar_seen"}, mem_r_m2s.arvalid, 1);
    check({tag, "_ar_wait"}, n, exp_wait);
    check({tag, "_araddr"}, mem_r_m2s.araddr, exp_addr);
    a   = mem_r_m2s.araddr;
    len = mem_r_m2s.arlen;
    mem_r_s2m.arready = 1'b1;
    #1;
    took_ifu = ifu_r_s2m.arready;
    took_lsu = lsu_r_s2m.arready;
    tick();
    mem_r_s2m.arready = 1'b0;
    if (took_ifu) ifu_r_m2s.arvalid = 1'b0;
    if (took_lsu) lsu_r_m2s.arvalid = 1'b0;
    for (int b = 0; b <= int'(len) && b < max_beats; b++) begin
      mem_r_s2m.rvalid = 1'b1;
      mem_r_s2m.rdata  = mem_word(a, b);
      mem_r_s2m.rresp  = resp;
      mem_r_s2m.rlast  = (b == int'(len));
      tick();
    end
    mem_r_s2m = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_r_s2m.rvalid && ifu_r_m2s.rready) begin
        check("ifu_beat_expected", ifu_q.size() != 0, 1);
        if (ifu_q.size() != 0) begin
          mon_ifu_b = ifu_q.pop_front();
          check("ifu_rdata", ifu_r_s2m.rdata, mon_ifu_b.data);
          check("ifu_rresp", ifu_r_s2m.rresp, mon_ifu_b.resp);
          check("ifu_rlast", ifu_r_s2m.rlast, mon_ifu_b.last);
          $display("[%0t] ifu beat data=%h resp=%0d last=%0d", $time, ifu_r_s2m.rdata,
                   ifu_r_s2m.rresp, ifu_r_s2m.rlast);
        end
      end
      if (lsu_r_s2m.rvalid && lsu_r_m2s.rready) begin
        check("lsu_beat_expected", lsu_q.size() != 0, 1);
        if (lsu_q.size() != 0) begin
          mon_lsu_b = lsu_q.pop_front();
          check("lsu_rdata", lsu_r_s2m.rdata, mon_lsu_b.data);
          check("lsu_rresp", lsu_r_s2m.rresp, mon_lsu_b.resp);
          check("lsu_rlast", lsu_r_s2m.rlast, mon_lsu_b.last);
          $display("[%0t] lsu beat data=%h resp=%0d last=%0d", $time, lsu_r_s2m.rdata,
                   lsu_r_s2m.rresp, lsu_r_s2m.rlast);
        end
      end
      if (lsu_w_s2m.bvalid && lsu_w_m2s.bready) begin
        check("b_expected", b_q.size() != 0, 1);
        if (b_q.size() != 0) begin
          mon_bresp = b_q.pop_front();
          check("lsu_bresp", lsu_w_s2m.bresp, mon_bresp);
          $display("[%0t] lsu write response bresp=%0d", $time, lsu_w_s2m.bresp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    ifu_r_m2s = '0;
    ifu_r_m2s.rready = 1'b1;
    lsu_r_m2s = '0;
    lsu_r_m2s.rready = 1'b1;
    lsu_w_m2s = '0;
    mem_r_s2m = '0;
    mem_w_s2m = '0;
    fp_ifu_r_m2s = '{araddr: 32'h0000_0100, arlen: 8'd0, arvalid: 1'b1, rready: 1'b1};
    fp_lsu_r_m2s = '{araddr: 32'h0000_0200, arlen: 8'd0, arvalid: 1'b1, rready: 1'b1};
    fp_lsu_w_m2s = '0;
    fp_mem_w_s2m = '0;
    fp_mem_r_s2m = '{arready: 1'b1, rdata: 32'hFEED_0001, rresp: 2'b00, rlast: 1'b1, rvalid: 1'b1};

    // Reset: pending read and a ready memory must not produce any handshake signals.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_r_s2m.arready = 1'b1;
    ifu_r_m2s.arvalid = 1'b1;
    #1;
    check("rst_mem_arvalid", mem_r_m2s.arvalid, 0);
    check("rst_ifu_arready", ifu_r_s2m.arready, 0);
    check("rst_mem_w_valids", {mem_w_m2s.awvalid, mem_w_m2s.wvalid, mem_w_m2s.bready}, 0);
    check("rst_fp_lsu_rvalid", fp_lsu_r_s2m.rvalid, 0);
    ifu_r_m2s.arvalid = 1'b0;
    mem_r_s2m.arready = 1'b0;

    // Lone IFU read: one-cycle arbitration latency, then back to IDLE.
    tick();
    rst = 1'b0;
    ifu_req(32'h3000_0000, 8'd0, 2'b00);
    serve_read("ifu_single", 32'h3000_0000, 1, 2'b00, 16);
    @(negedge clk);
    check("ifu_single_idle_rready", mem_r_m2s.rready, 0);

    // Fixed priority: LSU gets every grant, IFU never sees a beat.
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      check("fp_ifu_rvalid", fp_ifu_r_s2m.rvalid, 0);
      cnt += int'(fp_lsu_r_s2m.rvalid);
    end
    check("fp_lsu_grants", cnt, 4);

    // Round-robin ties from reset: LSU, IFU, then LSU, IFU again.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifu_req(32'h1000_0000, 8'd0, 2'b00);
    lsu_req(32'h2000_0000, 8'd0, 2'b01);
    serve_read("tie1_lsu", 32'h2000_0000, 1, 2'b01, 16);
    serve_read("tie1_ifu", 32'h1000_0000, 1, 2'b00, 16);
    ifu_req(32'h1000_0040, 8'd0, 2'b00);
    lsu_req(32'h2000_0040, 8'd0, 2'b11);
    serve_read("tie2_lsu", 32'h2000_0040, 1, 2'b11, 16);
    serve_read("tie2_ifu", 32'h1000_0040, 1, 2'b00, 16);

    // Four-beat IFU burst with an LSU request arriving mid-burst.
    ifu_req(32'h3000_1000, 8'd3, 2'b00);
    tick();
    lsu_req(32'h2000_0080, 8'd0, 2'b00);
    serve_read("burst_ifu", 32'h3000_1000, 0, 2'b00, 16);
    serve_read("burst_lsu", 32'h2000_0080, 1, 2'b00, 16);

    // Write beats a simultaneous IFU read; IFU waits for B plus one IDLE cycle.
    ifu_req(32'h3000_2000, 8'd0, 2'b00);
    lsu_wr_start(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
    mem_r_s2m.arready = 1'b1;
    mem_w_s2m.awready = 1'b1;
    mem_w_s2m.wready  = 1'b1;
    @(negedge clk);
    check("wr_idle_awvalid", mem_w_m2s.awvalid, 0);
    @(negedge clk);
    check("wr_grant_awvalid", mem_w_m2s.awvalid, 1);
    check("wr_awaddr", mem_w_m2s.awaddr, 32'h8000_0010);
    check("wr_wdata", mem_w_m2s.wdata, 32'hDEAD_BEEF);
    check("wr_mem_arvalid", mem_r_m2s.arvalid, 0);
    check("wr_ifu_arready", ifu_r_s2m.arready, 0);
    tick();
    mem_w_s2m.awready = 1'b0;
    mem_w_s2m.wready  = 1'b0;
    lsu_w_m2s.awvalid = 1'b0;
    lsu_w_m2s.wvalid  = 1'b0;
    lsu_w_m2s.wlast   = 1'b0;
    @(negedge clk);
    check("wr_wait_b_ifu_arready", ifu_r_s2m.arready, 0);
    check("wr_wait_b_bready", mem_w_m2s.bready, 1);
    tick();
    mem_w_s2m.bvalid = 1'b1;
    mem_w_s2m.bresp  = 2'b00;
    @(negedge clk);
    check("wr_b_ifu_arready", ifu_r_s2m.arready, 0);
    tick();
    mem_w_s2m.bvalid = 1'b0;
    @(negedge clk);
    check("wr_gap_ifu_arready", ifu_r_s2m.arready, 0);
    check("wr_gap_mem_arvalid", mem_r_m2s.arvalid, 0);
    mem_r_s2m.arready = 1'b0;
    serve_read("wr_then_ifu", 32'h3000_2000, 0, 2'b00, 16);

    // W completes three cycles before AW; error response is forwarded.
    lsu_wr_start(32'h8000_0020, 32'h1234_5678, 2'b10);
    mem_w_s2m.wready = 1'b1;
    tick();
    tick();
    mem_w_s2m.wready = 1'b0;
    lsu_w_m2s.wvalid = 1'b0;
    lsu_w_m2s.wlast  = 1'b0;
    @(negedge clk);
    check("w_first_awvalid", mem_w_m2s.awvalid, 1);
    check("w_first_wvalid", mem_w_m2s.wvalid, 0);
    tick();
    tick();
    mem_w_s2m.awready = 1'b1;
    tick();
    mem_w_s2m.awready = 1'b0;
    lsu_w_m2s.awvalid = 1'b0;
    mem_w_s2m.bvalid  = 1'b1;
    mem_w_s2m.bresp   = 2'b10;
    tick();
    mem_w_s2m.bvalid = 1'b0;
    mem_w_s2m.bresp  = 2'b00;
    @(negedge clk);
    check("w_first_idle_bready", mem_w_m2s.bready, 0);
    check("w_first_idle_bvalid", lsu_w_s2m.bvalid, 0);
    lsu_w_m2s.bready = 1'b0;

    // Reset in the middle of the second beat of an LSU burst.
    tick();
    lsu_req(32'h2000_0100, 8'd3, 2'b00);
    serve_read("rst_lsu", 32'h2000_0100, 1, 2'b00, 1);
    mem_r_s2m.rvalid = 1'b1;
    mem_r_s2m.rdata  = mem_word(32'h2000_0100, 1);
    mem_r_s2m.rlast  = 1'b0;
    #1;
    check("pre_rst_lsu_rvalid", lsu_r_s2m.rvalid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_lsu_rvalid", lsu_r_s2m.rvalid, 0);
    check("async_rst_mem_rready", mem_r_m2s.rready, 0);
    lsu_q.delete();
    mem_r_s2m = '0;
    tick();
    rst = 1'b0;
    ifu_req(32'h3000_3000, 8'd0, 2'b00);
    serve_read("post_rst_ifu", 32'h3000_3000, 1, 2'b00, 16);

    repeat (2) tick();
    check("ifu_q_drained", ifu_q.size(), 0);
    check("lsu_q_drained", lsu_q.size(), 0);
    check("b_q_drained", b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_axi_arb.md
YSYX_24080006_AXI_ARB -- requirements
Module: ysyx_24080006_axi_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin between IFU and LSU reads, 0 = fixed LSU-over-IFU priority.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ifu_r_m2s  input  axi_r_m2s_t  IFU read request: araddr, arlen, arvalid, rready.
REQ-005 SHALL have port ifu_r_s2m  output  axi_r_s2m_t  IFU read response: arready, rdata, rresp, rlast, rvalid.
REQ-006 SHALL have port lsu_r_m2s  input  axi_r_m2s_t  LSU read request.
REQ-007 SHALL have port lsu_r_s2m  output  axi_r_s2m_t  LSU read response.
REQ-008 SHALL have port lsu_w_m2s  input  axi_w_m2s_t  LSU write request: aw*, w* including wlast, bready.
REQ-009 SHALL have port lsu_w_s2m  output  axi_w_s2m_t  LSU write response: awready, wready, bvalid, bresp.
REQ-010 SHALL have port mem_r_m2s  output  axi_r_m2s_t  shared downstream read request.
REQ-011 SHALL have port mem_r_s2m  input  axi_r_s2m_t  shared downstream read response.
REQ-012 SHALL have port mem_w_m2s  output  axi_w_m2s_t  shared downstream write request.
REQ-013 SHALL have port mem_w_s2m  input  axi_w_s2m_t  shared downstream write response.

Function
REQ-014 SHALL implement FSM states IDLE, RD_IFU, RD_LSU, WR; at most one downstream transaction outstanding.
REQ-015 SHALL arbitrate only in IDLE; the selected state is entered on the next edge, giving one cycle of arbitration latency.
REQ-016 SHALL prioritise requests in IDLE: LSU awvalid highest; then LSU arvalid vs IFU arvalid per RR_EN.
REQ-017 SHALL, with RR_EN=1 and both reads requesting, grant the requester not granted last; a last_rd register resets to IFU, so LSU wins the first tie.
REQ-018 SHALL, with RR_EN=0, grant LSU read over IFU read on every tie.
REQ-019 SHALL, in RD_x, pass the granted request combinationally to mem_r_m2s and mem_r_s2m back to the granted port; data path adds zero cycles.
REQ-020 SHALL drive arready, rvalid and rlast of the non-granted read port to 0, and rdata/rresp to 0.
REQ-021 SHALL drive all mem_r_m2s valid/ready fields to 0 outside RD_IFU/RD_LSU, and all mem_w_m2s valid/ready fields to 0 outside WR.
REQ-022 SHALL leave RD_x for IDLE on the cycle after mem rvalid & granted rready & rlast; beats without rlast keep the grant.
REQ-023 SHALL, in WR, pass lsu_w_m2s/mem_w_s2m through and track aw_done and w_done flags (w_done set on the wlast handshake); AW and W may complete in either order or in the same cycle.
REQ-024 SHALL leave WR for IDLE on the cycle after bvalid & bready, clearing both flags; a B handshake before both flags are set is forwarded, and exit still occurs.
REQ-025 SHALL keep the grant until completion even if the granted requester deasserts arvalid/awvalid early.
REQ-026 SHALL forward rresp/bresp error codes unchanged without altering state behaviour.
REQ-027 SHALL insert exactly one IDLE cycle between consecutive transactions.
REQ-028 SHALL update last_rd on entry to RD_IFU/RD_LSU only.

Reset
REQ-029 SHALL, on reset assertion (including mid-transaction), asynchronously enter IDLE, clear aw_done/w_done, set last_rd=IFU, and drive every valid/ready output to 0.
REQ-030 SHALL first arbitrate on the first rising edge after reset deasserts.

Verification
REQ-031 SHALL cover: IFU arvalid alone, araddr=0x3000_0000, memory answers 1 beat -> mem arvalid rises 1 cycle later; IFU gets rdata and rlast; state returns to IDLE.
REQ-032 SHALL cover: IFU and LSU arvalid same cycle from reset, RR_EN=1 -> LSU granted first, IFU second; repeat tie -> LSU then IFU again; with RR_EN=0 -> LSU always first.
REQ-033 SHALL cover: LSU awvalid and IFU arvalid together -> WR granted; IFU arready stays 0 until B handshake plus one IDLE cycle.
REQ-034 SHALL cover: write with W handshake 3 cycles before AW, then bvalid with bresp=2'b10 -> lsu bresp=2'b10; return to IDLE.
REQ-035 SHALL cover: 4-beat IFU burst (arlen=3) -> grant held across beats, released only after the rlast beat; LSU request during burst waits.
REQ-036 SHALL cover: reset asserted mid-RD_LSU beat 2 -> outputs 0 immediately, not at the next edge; after release, a new IFU request is granted normally.
